stream_writer: RTL and testbench
================================

STREAM_WRITER -- requirements
Module: stream_writer

Interface
REQ-001 Parameter HDISP, default 800, active pixels per line.
REQ-002 Parameter VDISP, default 480, active lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, power of two, entries of 32 bits.
REQ-004 Port sys_clk  input  1  single system clock, 100 MHz; all logic on its rising edge.
REQ-005 Port sys_rst  input  1  synchronous, active-high reset.
REQ-006 Port wshb_ifs  wshb_if.slave  DATA_BYTES=4  pixel stream input from hw_support; uses cyc, stb, we, dat_ms, ack, dat_sm, err, rty.
REQ-007 Port wshb_ifm  wshb_if.master  DATA_BYTES=4  framebuffer write port to SDRAM; drives cyc, stb, we, adr, dat_ms, sel, cti, bte.
REQ-008 Port level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, for debug LEDs.

Function
REQ-009 Slave side SHALL assert wshb_ifs.ack combinationally when cyc & stb & we & FIFO not full, pushing dat_ms into the FIFO in that cycle.
REQ-010 Slave side SHALL hold ack low on a write while the FIFO is full; the word is neither dropped nor duplicated.
REQ-011 Slave reads (cyc & stb & ~we) SHALL be acked immediately with dat_sm = 0.
REQ-012 wshb_ifs.err and wshb_ifs.rty SHALL be constant 0.
REQ-013 Master FSM states: IDLE, WRITE.
REQ-014 IDLE -> WRITE when FIFO not empty; WRITE -> IDLE on ack when FIFO becomes empty in that cycle; otherwise stay in WRITE.
REQ-015 In WRITE: cyc = stb = 1, we = 1, sel = 4'hF, cti = 0, bte = 0, dat_ms = FIFO head, adr = 4 * pix_idx (byte address).
REQ-016 In IDLE: cyc = stb = we = 0; adr, dat_ms, sel are don't-care.
REQ-017 On wshb_ifm.ack the FIFO SHALL pop and pix_idx SHALL increment.
REQ-018 pix_idx SHALL wrap from HDISP*VDISP-1 to 0 (800x480: 383999 -> 0, adr 1535996 -> 0).
REQ-019 Simultaneous push and pop in one cycle SHALL leave occupancy unchanged, including at full and at empty.
REQ-020 Push at full SHALL be impossible per REQ-010; pop at empty SHALL be impossible per REQ-014.
REQ-021 Latency: a word acked on the slave at cycle N SHALL appear on wshb_ifm.dat_ms with stb high no earlier than cycle N+1 when the FIFO was empty.
REQ-022 wshb_ifm.stb and adr/dat_ms SHALL stay stable until ack.

Reset
REQ-023 sys_rst SHALL empty the FIFO, set pix_idx to 0, set the FSM to IDLE, and force level = 0, wshb_ifm.cyc = stb = we = 0.
REQ-024 Reset asserted mid-burst SHALL drop cyc/stb in the next cycle; buffered words are discarded.
REQ-025 While sys_rst is high, wshb_ifs.ack SHALL be 0.

Structure
REQ-026 HDISP, VDISP and the FSM state enum SHALL live in a shared package video_pkg.
REQ-027 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, level).
REQ-028 The block SHALL be instantiated in Top between wshb_if_stream and wshb_if_sdram, replacing their tie-offs.

Verification
REQ-029 Single write 32'hDEADBEEF with SDRAM ack after 2 cycles -> one master write, adr 0, dat_ms DEADBEEF, sel F; FIFO then empty, FSM IDLE.
REQ-030 20 back-to-back slave writes with SDRAM ack held low -> 16 acked, slave ack low from the 17th, level = 16; release ack -> remaining 4 accepted, in order.
REQ-031 HDISP=4, VDISP=2, 9 writes with immediate ack -> addresses 0,4,...,28, then 0 for the 9th word.
REQ-032 FIFO at 16 entries, simultaneous slave write and master ack -> both acked, level stays 16, order preserved.
REQ-033 sys_rst pulsed with 5 words buffered and stb high -> next cycle cyc = stb = 0, level = 0; next write goes to adr 0.
REQ-034 Slave read -> ack same cycle, dat_sm = 0, FIFO untouched.

Source files
------------

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video timing constants and framebuffer writer state type
package video_pkg;

  localparam int HDISP = 800;
  localparam int VDISP = 480;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_t;

  // Next pixel index with wrap at the end of the frame.
  function automatic int unsigned pix_next(input int unsigned idx, input int unsigned npix);
    return (idx == npix - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// rtl/wshb_if.sv - Wishbone bus bundle with master and slave views
interface wshb_if #(
  parameter int DATA_BYTES = 4
);

  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [31:0]               adr;
  logic [8*DATA_BYTES-1:0]   dat_ms;
  logic [8*DATA_BYTES-1:0]   dat_sm;
  logic [DATA_BYTES-1:0]     sel;
  logic [2:0]                cti;
  logic [1:0]                bte;
  logic                      ack;
  logic                      err;
  logic                      rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  ack
  );

  modport slave (
    input  cyc, stb, we, dat_ms,
    output ack, dat_sm, err, rty
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push while full is accepted only when a pop
// frees the slot in the same cycle
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/stream_writer.sv
// rtl/stream_writer.sv - buffers the incoming pixel stream and writes it into the
// SDRAM framebuffer at consecutive word addresses, wrapping once per frame
module stream_writer #(
  parameter int HDISP      = video_pkg::HDISP,
  parameter int VDISP      = video_pkg::VDISP,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  wshb_if.slave                         wshb_ifs,
  wshb_if.master                        wshb_ifm,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  import video_pkg::*;

  localparam int NPIX  = HDISP * VDISP;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  wr_state_t        state;
  wr_state_t        state_next;
  logic [PIX_W-1:0] pix_idx;
  logic             fifo_full;
  logic             fifo_empty;
  logic [31:0]      fifo_head;
  logic             s_write;
  logic             push;
  logic             pop;

  assign s_write = wshb_ifs.cyc & wshb_ifs.stb & wshb_ifs.we;
  assign pop     = (state == ST_WRITE) & wshb_ifm.ack;
  // A full FIFO still accepts a word when the master pops in the same cycle.
  assign push    = ~sys_rst & s_write & (~fifo_full | pop);

  assign wshb_ifs.ack    = ~sys_rst & wshb_ifs.cyc & wshb_ifs.stb & (~wshb_ifs.we | ~fifo_full | pop);
  assign wshb_ifs.dat_sm = '0;
  assign wshb_ifs.err    = 1'b0;
  assign wshb_ifs.rty    = 1'b0;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .push      (push),
    .push_data (wshb_ifs.dat_ms),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_next = ST_WRITE;
      ST_WRITE: if (pop && !push && level == LW'(1)) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= ST_IDLE;
      pix_idx <= '0;
    end else begin
      state <= state_next;
      if (pop) pix_idx <= PIX_W'(pix_next(32'(pix_idx), NPIX));
    end
  end

  assign wshb_ifm.cyc    = (state == ST_WRITE);
  assign wshb_ifm.stb    = (state == ST_WRITE);
  assign wshb_ifm.we     = (state == ST_WRITE);
  assign wshb_ifm.sel    = '1;
  assign wshb_ifm.cti    = 3'b000;
  assign wshb_ifm.bte    = 2'b00;
  assign wshb_ifm.dat_ms = fifo_head;
  assign wshb_ifm.adr    = 32'({pix_idx, 2'b00});

endmodule

// File: tb/tb_stream_writer.sv
// tb/tb_stream_writer.sv - directed bench for stream_writer on a 4x2 frame
module tb_stream_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] level;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  wshb_if #(.DATA_BYTES(4)) s_if ();
  wshb_if #(.DATA_BYTES(4)) m_if ();

  stream_writer #(
    .HDISP      (4),
    .VDISP      (2),
    .FIFO_DEPTH (16)
  ) dut (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .wshb_ifs (s_if),
    .wshb_ifm (m_if),
    .level    (level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_idle();
    s_if.cyc = 1'b0; s_if.stb = 1'b0; s_if.we = 1'b0; s_if.dat_ms = '0;
  endtask

  // Scoreboard: words accepted on the slave must leave the master in order, at 4*(n mod 8).
  logic [31:0] exp_q [$];
  logic [31:0] adr_log [$];
  int          exp_idx = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      adr_log.delete();
      exp_idx = 0;
    end else begin
      if (m_if.cyc && m_if.stb && m_if.ack) begin
        if (exp_q.size() == 0) chk("master_unexpected_write", 32'd1, 32'd0);
        else begin
          chk("master_dat", m_if.dat_ms, exp_q.pop_front());
          chk("master_adr", m_if.adr, 32'(4 * (exp_idx % 8)));
          chk("master_we_sel", {27'd0, m_if.we, m_if.sel}, 32'h1F);
          adr_log.push_back(m_if.adr);
          exp_idx++;
        end
      end
      if (s_if.cyc && s_if.stb && s_if.we && s_if.ack) exp_q.push_back(s_if.dat_ms);
    end
  end

  task automatic reset_dut();
    tick();
    rst = 1'b1; s_idle(); m_if.ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_words(input int n, input logic [31:0] base, input int budget);
    int k = 0;
    for (int c = 0; c < budget && k < n; c++) begin
      tick();
      s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.we = 1'b1; s_if.dat_ms = base + k;
      @(negedge clk);
      if (s_if.ack) k++;
    end
    tick();
    s_idle();
    chk("write_accept_count", k, n);
  endtask

  task automatic drain(input string name);
    logic done = 1'b0;
    m_if.ack = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      @(negedge clk);
      if (level == 0 && !m_if.cyc) done = 1'b1;
    end
    m_if.ack = 1'b0;
    chk(name, done, 1'b1);
  endtask

  task automatic wait_stb(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      @(negedge clk);
      if (m_if.stb) seen = 1'b1;
    end
    chk(name, seen, 1'b1);
  endtask

  typedef struct {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] dat;
    logic        exp_ack;
    int          exp_level;
  } vec_t;

  vec_t vecs [11];

  logic [31:0] a0, d0;
  int          k;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h2222_2222, 1'b0, 0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h3333_3333, 1'b1, 0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'hA000_0001, 1'b1, 0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h5555_5555, 1'b1, 1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'hA000_0002, 1'b1, 1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'hA000_0003, 1'b1, 2};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 3};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'hA000_0004, 1'b1, 3};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 4};

    rst = 1'b1;
    s_idle();
    m_if.ack = 1'b0;
    tick();
    s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.we = 1'b1; s_if.dat_ms = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("reset_slave_ack", s_if.ack, 1'b0);
    tick();
    s_idle();
    @(negedge clk);
    chk("reset_level", level, 0);
    chk("reset_master_cyc_stb_we", {m_if.cyc, m_if.stb, m_if.we}, 3'b000);
    rst = 1'b0;

    // Single write, SDRAM acks after two wait cycles.
    write_words(1, 32'hDEAD_BEEF, 4);
    wait_stb("single_stb_seen");
    a0 = m_if.adr; d0 = m_if.dat_ms;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      chk("single_stable", {31'd0, m_if.stb}, 32'd1);
      chk("single_adr_stable", m_if.adr, a0);
      chk("single_dat_stable", m_if.dat_ms, d0);
    end
    tick();
    m_if.ack = 1'b1;
    @(negedge clk);
    chk("single_adr", m_if.adr, 32'h0);
    chk("single_dat", m_if.dat_ms, 32'hDEAD_BEEF);
    chk("single_sel", m_if.sel, 4'hF);
    tick();
    m_if.ack = 1'b0;
    @(negedge clk);
    chk("single_idle_after", {m_if.cyc, m_if.stb}, 2'b00);
    chk("single_level_after", level, 0);

    // Slave-side vector table; master ack held low so words accumulate.
    for (int i = 0; i < 11; i++) begin
      tick();
      s_if.cyc = vecs[i].cyc; s_if.stb = vecs[i].stb; s_if.we = vecs[i].we; s_if.dat_ms = vecs[i].dat;
      @(negedge clk);
      chk($sformatf("vec%0d_ack", i), s_if.ack, vecs[i].exp_ack);
      chk($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
      chk($sformatf("vec%0d_dat_sm", i), s_if.dat_sm, 32'h0);
      chk($sformatf("vec%0d_err_rty", i), {s_if.err, s_if.rty}, 2'b00);
    end
    s_idle();
    drain("table_drain");

    // 20 back-to-back writes against a stalled SDRAM.
    reset_dut();
    k = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.we = 1'b1; s_if.dat_ms = 32'h3000_0000 + k;
      @(negedge clk);
      if (c == 16) chk("burst_ack_low_17th", s_if.ack, 1'b0);
      if (s_if.ack) k++;
    end
    chk("burst_accepted", k, 16);
    chk("burst_level_full", level, 16);
    m_if.ack = 1'b1;
    for (int c = 0; c < 40 && k < 20; c++) begin
      tick();
      s_if.dat_ms = 32'h3000_0000 + k;
      @(negedge clk);
      if (s_if.ack) k++;
    end
    tick();
    s_idle();
    chk("burst_remaining_accepted", k, 20);
    drain("burst_drain");

    // Full FIFO with simultaneous slave write and master ack.
    reset_dut();
    write_words(16, 32'h4000_0000, 24);
    @(negedge clk);
    chk("full_level", level, 16);
    tick();
    s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.we = 1'b1; s_if.dat_ms = 32'h4000_00FF;
    m_if.ack = 1'b1;
    @(negedge clk);
    chk("full_slave_ack", s_if.ack, 1'b1);
    chk("full_master_stb", m_if.stb, 1'b1);
    tick();
    s_idle();
    m_if.ack = 1'b0;
    @(negedge clk);
    chk("full_level_kept", level, 16);
    drain("full_drain");

    // Reset mid-burst.
    reset_dut();
    write_words(5, 32'h5000_0000, 8);
    @(negedge clk);
    chk("midrst_level5", level, 5);
    chk("midrst_stb_high", m_if.stb, 1'b1);
    tick();
    rst = 1'b1;
    s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.we = 1'b1; s_if.dat_ms = 32'h5BAD_5BAD;
    @(negedge clk);
    chk("midrst_slave_ack", s_if.ack, 1'b0);
    tick();
    rst = 1'b0;
    s_idle();
    @(negedge clk);
    chk("midrst_cyc_stb", {m_if.cyc, m_if.stb}, 2'b00);
    chk("midrst_level0", level, 0);
    write_words(1, 32'hCAFE_F00D, 4);
    wait_stb("midrst_stb_seen");
    chk("midrst_next_adr", m_if.adr, 32'h0);
    chk("midrst_next_dat", m_if.dat_ms, 32'hCAFE_F00D);
    drain("midrst_drain");

    // Frame wrap on 4x2: nine words with immediate ack.
    reset_dut();
    m_if.ack = 1'b1;
    write_words(9, 32'h9000_0000, 20);
    drain("wrap_drain");
    chk("wrap_count", adr_log.size(), 9);
    if (adr_log.size() == 9) begin
      chk("wrap_adr7", adr_log[7], 32'd28);
      chk("wrap_adr8", adr_log[8], 32'd0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
